// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder: WIDTH-bit operands summed CHUNK bits per cycle through one slice with a registered carry.
// Optional subtract mode when SERIAL_CHUNK_ADDER_SUB_EN is defined (adds a 'sub' input).
module serial_chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("serial_chunk_adder: WIDTH must be a multiple of CHUNK");
    end

    // Valid/ready: a transfer happens on a rising edge where valid and ready are both 1;
    // in_ready and out_valid depend only on state, never combinationally on the inputs.
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic [WIDTH-1:0]   a_q, b_q, sum_q;
    logic               carry_out_q, overflow_q;

    logic               accept;
    logic [WIDTH-1:0]   b_load;
    logic               carry_load;
    logic [CHUNK-1:0]   a_s, b_s, s;
    logic               c, msb_cin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)          state_d = RUN;
            RUN:     if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    if (out_ready)         state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid & in_ready;

`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    // Subtract as a + ~b + 1; carry_in is ignored in this mode.
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : carry_in;
`else
    assign b_load     = b;
    assign carry_load = carry_in;
`endif

    always_comb begin
        a_s      = a_q[idx_q*CHUNK +: CHUNK];
        b_s      = b_q[idx_q*CHUNK +: CHUNK];
        {c, s}   = {1'b0, a_s} + {1'b0, b_s} + {{CHUNK{1'b0}}, carry_q};
        // Carry into the slice MSB recovered from the MSB sum bit.
        msb_cin  = a_s[CHUNK-1] ^ b_s[CHUNK-1] ^ s[CHUNK-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b_load;
            carry_q <= carry_load;
            idx_q   <= '0;
        end else if (state_q == RUN) begin
            sum_q[idx_q*CHUNK +: CHUNK] <= s;
            carry_q <= c;
            if (idx_q == LAST_IDX) begin
                idx_q       <= '0;
                carry_out_q <= c;
                overflow_q  <= msb_cin ^ c;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign sum       = sum_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: doc/serial_chunk_adder.md
Name: serial_chunk_adder

Overview:
- Multi-cycle parametrised adder. Adds two WIDTH-bit operands CHUNK bits per cycle.
- A registered carry links each chunk to the next, so wide adds reuse one CHUNK-bit adder slice.
- Valid/ready handshakes on both input and output. Sits between an operand source and a result consumer in lab datapaths.
- Successor to the single-bit combinational full adder; adds width, chunking, sequencing and signed overflow.

Parameters:
- WIDTH, 32: operand and sum width in bits.
- CHUNK, 4: bits added per cycle. WIDTH % CHUNK must be 0, otherwise elaboration fails with $error.
- NCHUNK = WIDTH/CHUNK is a derived localparam. It is not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- carry_in  in  1  carry into bit 0.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  registered sum.
- carry_out  out  1  carry out of bit WIDTH-1.
- overflow  out  1  signed overflow (two's complement).

Behaviour:
- One clock domain. Reset is asynchronous and active-high on rst.
- Reset values:
  - state = IDLE, chunk counter = 0, internal carry = 0.
  - sum = 0, carry_out = 0, overflow = 0, out_valid = 0.
  - in_ready = (state == IDLE), so it reads 1 while rst is held. Inputs are ignored while rst = 1.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid & in_ready at edge E0: capture a, b and carry_in into internal registers, clear the counter, load carry = carry_in, go to RUN.
- RUN:
  - in_ready = 0, out_valid = 0.
  - Each edge: {c, s} = a_reg[idx*CHUNK +: CHUNK] + b_reg[idx*CHUNK +: CHUNK] + carry.
  - Write s into sum[idx*CHUNK +: CHUNK] and update carry = c.
  - Counter increments by 1. When the counter reaches NCHUNK-1, go to DONE on that edge.
- DONE:
  - Entered on the final RUN edge, which also loads carry_out and overflow.
  - overflow = carry into MSB XOR carry out of MSB. Both are taken from the final chunk.
  - out_valid = 1, in_ready = 0.
  - sum, carry_out and overflow are held stable until out_valid & out_ready.
  - On that handshake edge go to IDLE. sum, carry_out and overflow keep their values.
- Latency: out_valid rises NCHUNK cycles after the accepting edge E0.
- Minimum issue interval: NCHUNK+2 cycles. Accept at E0, earliest result handshake at E0+NCHUNK+1, next accept at E0+NCHUNK+2.
- Operand registers are loaded only on the input handshake. Changes on a, b or carry_in after acceptance have no effect.
- in_valid while in RUN or DONE is ignored and not queued.
- out_ready while not in DONE is ignored.
- CHUNK == WIDTH (NCHUNK = 1): a single RUN cycle, then DONE.
- rst asserted mid-operation: abort immediately, all regs return to reset values, the partial result is discarded.
- All arithmetic is unsigned modulo 2^CHUNK per slice. No X-propagation from unused bits.

Optional Feature:
- Macro SERIAL_CHUNK_ADDER_SUB_EN.
- Defined:
  - Extra port sub, in, 1, captured on the input handshake with the operands.
  - If the captured sub = 1: the b register loads ~b, the initial carry is forced to 1 and carry_in is ignored, so sum = a - b.
  - carry_out = 1 means no borrow.
  - overflow uses the same MSB rule, giving signed subtract overflow.
- Not defined: no sub port; the block is add-only as described above.

Test Plan:
- WIDTH=32, CHUNK=4. Accept a=0xFFFFFFFF, b=0x1, cin=0 -> out_valid exactly 8 cycles later; sum=0x00000000, carry_out=1, overflow=0.
- a=0x7FFFFFFF, b=0x1, cin=0 -> sum=0x80000000, carry_out=0, overflow=1.
- a=0x12345678, b=0x0F0F0F0F, cin=1 -> sum=0x21436588, carry_out=0, overflow=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE and pulse in_valid with new operands -> outputs stable, in_ready=0, new operands ignored. out_ready=1 -> in_ready=1 the next cycle, and the next op gives a correct result.
- Assert rst 3 cycles into RUN -> out_valid=0, sum=0, in_ready=1. A subsequent add of 0x5 + 0x3 gives sum=0x8.
- With SERIAL_CHUNK_ADDER_SUB_EN, sub=1, a=5, b=7 -> sum=0xFFFFFFFE, carry_out=0, overflow=0. Repeat with CHUNK=32 -> same result after 1 cycle.
